// File: rtl/nv_nvdla_pdp_grp_pkg.sv
`default_nettype none
// ============================================================================
// Module : nv_nvdla_pdp_grp_pkg
// Brief  : Shared encodings for the PDP ping-pong register-group tracker.
// Rev    : 1.0  initial release
// ============================================================================
package nv_nvdla_pdp_grp_pkg;

  localparam int PDP_GRP_STATUS_W = 2;

  localparam logic [PDP_GRP_STATUS_W-1:0] PDP_GRP_IDLE    = 2'd0;
  localparam logic [PDP_GRP_STATUS_W-1:0] PDP_GRP_RUNNING = 2'd1;
  localparam logic [PDP_GRP_STATUS_W-1:0] PDP_GRP_PENDING = 2'd2;

  localparam int PDP_GRP_STATE_W = 2;

  localparam logic [PDP_GRP_STATE_W-1:0] S_IDLE = 2'd0;
  localparam logic [PDP_GRP_STATE_W-1:0] S_GAP  = 2'd1;
  localparam logic [PDP_GRP_STATE_W-1:0] S_RUN  = 2'd2;

endpackage
`default_nettype wire

// File: rtl/nv_nvdla_pdp_grp_tracker.sv
`default_nettype none
// ============================================================================
// Module : nv_nvdla_pdp_grp_tracker
// Brief  : Sequences the two PDP register groups onto the datapath and keeps
//          the consumer pointer and per-group status.
// Rev    : 1.0  initial release
// ============================================================================
module nv_nvdla_pdp_grp_tracker
  import nv_nvdla_pdp_grp_pkg::*;
#(
  parameter int LAUNCH_GAP = 2,
  parameter int GAP_W      = 4
) (
  input  logic                        nvdla_core_clk,
  input  logic                        nvdla_core_rst,
  input  logic                        producer,
  input  logic                        op_en_trigger,
  input  logic                        dp_done,
  output logic                        consumer,
  output logic [PDP_GRP_STATUS_W-1:0] status_0,
  output logic [PDP_GRP_STATUS_W-1:0] status_1,
  output logic                        dp_op_en,
  output logic                        dp_grp,
  output logic [1:0]                  done_intr,
  output logic                        op_en_err
);

  logic [PDP_GRP_STATE_W-1:0]  r_state;
  logic [PDP_GRP_STATE_W-1:0]  w_state_nxt;
  logic [GAP_W-1:0]            r_cnt;
  logic                        r_consumer;
  logic [PDP_GRP_STATUS_W-1:0] r_status [2];
  logic [PDP_GRP_STATUS_W-1:0] w_status_post_done [2];
  logic [1:0]                  r_done_intr;
  logic                        r_op_en_err;
  logic                        w_cons_pending;
  logic                        w_gap_load;
  logic                        w_launch;
  logic                        w_done;
  logic                        w_dp_op_en;
  logic                        w_trig_ok;

  assign w_cons_pending = (r_status[r_consumer] == PDP_GRP_PENDING);

  always_ff @(posedge nvdla_core_clk) begin
    if (nvdla_core_rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_cons_pending) w_state_nxt = S_GAP;
      S_GAP:   if (r_cnt == '0)    w_state_nxt = S_RUN;
      S_RUN:   if (dp_done)        w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_gap_load = 1'b0;
    w_launch   = 1'b0;
    w_done     = 1'b0;
    w_dp_op_en = 1'b0;
    case (r_state)
      S_IDLE:  w_gap_load = w_cons_pending;
      S_GAP:   w_launch   = (r_cnt == '0);
      S_RUN: begin
        w_dp_op_en = 1'b1;
        w_done     = dp_done;
      end
      default: ;
    endcase
  end

  always_ff @(posedge nvdla_core_clk) begin
    if (nvdla_core_rst) begin
      r_cnt <= '0;
    end else if (w_gap_load) begin
      r_cnt <= GAP_W'(LAUNCH_GAP);
    end else if ((r_state == S_GAP) && (r_cnt != '0)) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  // A completing layer frees its group before the trigger is judged, so a
  // trigger aimed at the group that just finished is accepted.
  always_comb begin
    for (int g = 0; g < 2; g++) begin
      w_status_post_done[g] = (w_done && (r_consumer == 1'(g))) ? PDP_GRP_IDLE : r_status[g];
    end
  end

  assign w_trig_ok = op_en_trigger && (w_status_post_done[producer] == PDP_GRP_IDLE);

  always_ff @(posedge nvdla_core_clk) begin
    if (nvdla_core_rst) begin
      r_status[0] <= PDP_GRP_IDLE;
      r_status[1] <= PDP_GRP_IDLE;
      r_consumer  <= 1'b0;
      r_done_intr <= 2'b00;
      r_op_en_err <= 1'b0;
    end else begin
      for (int g = 0; g < 2; g++) begin
        if (w_trig_ok && (producer == 1'(g))) begin
          r_status[g] <= PDP_GRP_PENDING;
        end else if (w_launch && (r_consumer == 1'(g))) begin
          r_status[g] <= PDP_GRP_RUNNING;
        end else begin
          r_status[g] <= w_status_post_done[g];
        end
      end
      if (w_done) begin
        r_consumer <= ~r_consumer;
      end
      r_done_intr <= {w_done & r_consumer, w_done & ~r_consumer};
      r_op_en_err <= op_en_trigger & ~w_trig_ok;
    end
  end

  assign consumer  = r_consumer;
  assign dp_grp    = r_consumer;
  assign status_0  = r_status[0];
  assign status_1  = r_status[1];
  assign dp_op_en  = w_dp_op_en;
  assign done_intr = r_done_intr;
  assign op_en_err = r_op_en_err;

endmodule
`default_nettype wire

// File: tb/tb_nv_nvdla_pdp_grp_tracker.sv
`default_nettype none
// ============================================================================
// Module : tb_nv_nvdla_pdp_grp_tracker
// Brief  : Scoreboard bench for the PDP register-group tracker; an
//          event-scheduling reference model predicts every cycle's outputs.
// Rev    : 1.0  initial release
// ============================================================================
module tb_nv_nvdla_pdp_grp_tracker;

  localparam int GAP = 2;
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_PEND = 2'd2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       producer = 1'b0;
  logic       trig = 1'b0;
  logic       dp_done = 1'b0;
  logic       consumer;
  logic [1:0] status_0;
  logic [1:0] status_1;
  logic       dp_op_en;
  logic       dp_grp;
  logic [1:0] done_intr;
  logic       op_en_err;

  nv_nvdla_pdp_grp_tracker #(
    .LAUNCH_GAP (GAP),
    .GAP_W      (4)
  ) u_dut (
    .nvdla_core_clk (clk),
    .nvdla_core_rst (rst),
    .producer       (producer),
    .op_en_trigger  (trig),
    .dp_done        (dp_done),
    .consumer       (consumer),
    .status_0       (status_0),
    .status_1       (status_1),
    .dp_op_en       (dp_op_en),
    .dp_grp         (dp_grp),
    .done_intr      (done_intr),
    .op_en_err      (op_en_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         edge_no;
    logic [1:0] st0;
    logic [1:0] st1;
    logic       cons;
    logic       op_en;
    logic [1:0] intr;
    logic       err;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;
  int   mon_edge = 0;

  // Reference model: group status plus the edge at which the next launch is due.
  logic [1:0] m_st [2];
  logic       m_cons;
  bit         m_run;
  int         m_run_edge;
  int         m_idle_entry;
  int         m_pend_edge [2];
  int         m_edge = 0;

  task automatic model_edge(input bit r, input bit t, input bit p, input bit d);
    exp_t e;
    int   g;
    m_edge++;
    e.intr = 2'b00;
    e.err  = 1'b0;
    if (r) begin
      m_st[0] = ST_IDLE;
      m_st[1] = ST_IDLE;
      m_cons = 1'b0;
      m_run = 1'b0;
      m_run_edge = -1;
      m_idle_entry = m_edge;
    end else begin
      if (m_run && d) begin
        e.intr[m_cons] = 1'b1;
        m_st[m_cons] = ST_IDLE;
        m_cons = ~m_cons;
        m_run = 1'b0;
        m_run_edge = -1;
        m_idle_entry = m_edge;
      end
      if (t) begin
        if (m_st[p] == ST_IDLE) begin
          m_st[p] = ST_PEND;
          m_pend_edge[p] = m_edge;
        end else begin
          e.err = 1'b1;
        end
      end
      if (!m_run && (m_run_edge == m_edge)) begin
        m_st[m_cons] = ST_RUN;
        m_run = 1'b1;
        m_run_edge = -1;
      end
      if (!m_run && (m_run_edge < 0) && (m_st[m_cons] == ST_PEND)) begin
        g = (m_idle_entry > m_pend_edge[m_cons]) ? m_idle_entry + 1 : m_pend_edge[m_cons] + 1;
        m_run_edge = g + GAP + 1;
      end
    end
    e.edge_no = m_edge;
    e.st0     = m_st[0];
    e.st1     = m_st[1];
    e.cons    = m_cons;
    e.op_en   = m_run;
    exp_q.push_back(e);
  endtask

  task automatic cyc(input bit r, input bit t, input bit p, input bit d);
    rst      = r;
    trig     = t;
    producer = p;
    dp_done  = d;
    model_edge(r, t, p, d);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic chk(input string name, input int edge_no, input logic [7:0] act, input logic [7:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s edge=%0d actual=%0h required=%0h", name, edge_no, act, req);
    end
  endtask

  always @(posedge clk) mon_edge <= mon_edge + 1;

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL scoreboard_empty edge=%0d actual=0 required=1", mon_edge);
      end else begin
        e = exp_q.pop_front();
        chk("edge_align", mon_edge, 8'(mon_edge), 8'(e.edge_no));
        chk("status_0",  e.edge_no, 8'(status_0),  8'(e.st0));
        chk("status_1",  e.edge_no, 8'(status_1),  8'(e.st1));
        chk("consumer",  e.edge_no, 8'(consumer),  8'(e.cons));
        chk("dp_grp",    e.edge_no, 8'(dp_grp),    8'(e.cons));
        chk("dp_op_en",  e.edge_no, 8'(dp_op_en),  8'(e.op_en));
        chk("done_intr", e.edge_no, 8'(done_intr), 8'(e.intr));
        chk("op_en_err", e.edge_no, 8'(op_en_err), 8'(e.err));
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog edge=%0d actual=running required=finished", mon_edge);
    $fatal(1, "watchdog expired");
  end

  initial begin
    m_run_edge = -1;
    m_idle_entry = 0;
    m_pend_edge[0] = 0;
    m_pend_edge[1] = 0;
    m_st[0] = ST_IDLE;
    m_st[1] = ST_IDLE;
    m_cons = 1'b0;
    m_run = 1'b0;

    // Single layer on group 0
    cyc(1, 0, 0, 0); cyc(1, 0, 0, 0); cyc(1, 0, 0, 0);
    idle(6);
    cyc(0, 1, 0, 0);
    idle(19);
    cyc(0, 0, 0, 1);
    idle(5);

    // Ping-pong
    cyc(1, 0, 0, 0);
    cyc(0, 1, 0, 0); idle(6);
    cyc(0, 1, 1, 0); idle(5);
    cyc(0, 0, 0, 1); idle(8);
    cyc(0, 0, 0, 1); idle(4);

    // Reject while PENDING and while RUNNING
    cyc(1, 0, 0, 0);
    cyc(0, 1, 0, 0);
    cyc(0, 1, 0, 0); idle(6);
    cyc(0, 1, 0, 0); idle(3);
    cyc(0, 0, 0, 1); idle(3);

    // Done and trigger on the same cycle
    cyc(1, 0, 0, 0);
    cyc(0, 1, 0, 0); idle(8);
    cyc(0, 1, 0, 1); idle(6);
    cyc(0, 1, 1, 0); idle(8);
    cyc(0, 0, 0, 1); idle(8);
    cyc(0, 0, 0, 1); idle(3);

    // Spurious done in idle and during the launch gap
    cyc(1, 0, 0, 0);
    cyc(0, 0, 0, 1);
    cyc(0, 1, 0, 0);
    cyc(0, 0, 0, 1); cyc(0, 0, 0, 1); cyc(0, 0, 0, 1);
    idle(4);
    cyc(0, 0, 0, 1); idle(3);

    // Reset mid-run with the other group pending, then reset with trigger
    cyc(1, 0, 0, 0);
    cyc(0, 1, 0, 0); idle(1);
    cyc(0, 1, 1, 0); idle(6);
    cyc(1, 0, 0, 1);
    cyc(0, 0, 0, 1); idle(3);
    cyc(1, 1, 0, 0); idle(8);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      cyc(($urandom_range(0, 299) == 0), ($urandom_range(0, 4) == 0),
          1'($urandom_range(0, 1)), ($urandom_range(0, 5) == 0));
    end
    idle(2);

    #6;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain edge=%0d actual=%0d required=0", mon_edge, exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
